// File: rtl/led_dimmer_pkg.sv
// Shared types and register map for the LED PWM dimmer.
package led_dimmer_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  localparam logic [4:0] ADDR_DUTY0    = 5'd0;
  localparam logic [4:0] ADDR_PRESCALE = 5'd4;
  localparam logic [4:0] ADDR_STEP     = 5'd5;
  localparam logic [4:0] ADDR_LEVEL    = 5'd6;

endpackage

// File: rtl/led_fade_channel.sv
// One dimmer channel: fade FSM and brightness level, advanced once per PWM period.
module led_fade_channel
  import led_dimmer_pkg::*;
#(
  parameter int unsigned RES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           boundary,
  input  logic           blink,
  input  logic [RES-1:0] duty,
  input  logic [RES-1:0] step,
  output logic [RES-1:0] level
);

  fade_state_t    state_q, state_d;
  logic [RES-1:0] level_q, level_d;
  logic [RES:0]   sum, diff;
  logic [RES-1:0] up_level, down_level;
  fade_state_t    up_state, down_state;

  // One extra bit so the step never wraps; results saturate to duty or zero.
  always_comb begin
    sum  = {1'b0, level_q} + {1'b0, step};
    diff = {1'b0, level_q} - {1'b0, step};
    up_level   = (step == '0 || sum > {1'b0, duty}) ? duty : sum[RES-1:0];
    down_level = (step == '0 || diff[RES]) ? '0 : diff[RES-1:0];
    up_state   = (up_level == duty) ? ON : RISE;
    down_state = (down_level == '0) ? OFF : FALL;
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (boundary) begin
      unique case (state_q)
        OFF: begin
          if (blink) begin
            level_d = up_level;
            state_d = up_state;
          end
        end
        RISE, FALL: begin
          if (blink) begin
            level_d = up_level;
            state_d = up_state;
          end else begin
            level_d = down_level;
            state_d = down_state;
          end
        end
        ON: begin
          if (blink) begin
            level_d = duty;
          end else begin
            level_d = down_level;
            state_d = down_state;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_pwm_dimmer.sv
// Bus-programmable PWM dimmer that fades each LED channel in and out on blink requests.
module led_pwm_dimmer
  import led_dimmer_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned RES = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  blink_in,
  output logic [W-1:0]  led
);

  logic [RES-1:0]   duty_q [W];
  logic [15:0]      prescale_q, pre_cnt_q, pre_cnt_d;
  logic [RES-1:0]   step_q;
  logic [RES-1:0]   cnt_q, cnt_d;
  logic [W-1:0]     led_q;
  logic [W*RES-1:0] level_flat;
  logic [31:0]      level_word;
  logic             wr_en, tick, boundary;
  logic             unused_bus;

  // rd_data is purely address-decoded, so the read strobe carries no information.
  assign unused_bus = ^{read, wr_data[31:16]};

  assign wr_en    = cs && write;
  assign tick     = (pre_cnt_q == prescale_q);
  assign boundary = tick && (cnt_q == '1);

  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
    if (wr_en && addr == ADDR_PRESCALE) pre_cnt_d = '0;
    cnt_d = tick ? cnt_q + RES'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      led_q      <= '0;
      for (int i = 0; i < W; i++) duty_q[i] <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      if (wr_en) begin
        if (addr == ADDR_PRESCALE) prescale_q <= wr_data[15:0];
        if (addr == ADDR_STEP)     step_q     <= wr_data[RES-1:0];
        for (int i = 0; i < W; i++) begin
          if (addr == ADDR_DUTY0 + 5'(i)) duty_q[i] <= wr_data[RES-1:0];
        end
      end
      for (int i = 0; i < W; i++) led_q[i] <= (cnt_q < level_flat[i*RES +: RES]);
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_ch
    led_fade_channel #(
      .RES(RES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .boundary(boundary),
      .blink   (blink_in[i]),
      .duty    (duty_q[i]),
      .step    (step_q),
      .level   (level_flat[i*RES +: RES])
    );
  end

  if (W * RES >= 32) begin : g_lw_trunc
    assign level_word = level_flat[31:0];
  end else begin : g_lw_ext
    assign level_word = {{(32 - W * RES){1'b0}}, level_flat};
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < W; i++) begin
      if (addr == ADDR_DUTY0 + 5'(i)) rd_data = 32'(duty_q[i]);
    end
    if (addr == ADDR_PRESCALE) rd_data = 32'(prescale_q);
    if (addr == ADDR_STEP)     rd_data = 32'(step_q);
    if (addr == ADDR_LEVEL)    rd_data = level_word;
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Randomised and directed bench for led_pwm_dimmer with a queue-based scoreboard.
module tb_led_pwm_dimmer;

  localparam int S_OFF  = 0;
  localparam int S_RISE = 1;
  localparam int S_ON   = 2;
  localparam int S_FALL = 3;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  blink_in, led;

  always #5 clk = ~clk;

  led_pwm_dimmer #(
    .W  (4),
    .RES(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .blink_in(blink_in),
    .led     (led)
  );

  typedef struct {
    logic [3:0]  led;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model state, plain integers.
  int       m_duty[4];
  int       m_level[4];
  int       m_state[4];
  int       m_pre, m_step, m_pc, m_cnt;
  bit [3:0] m_led;

  function automatic void model_fade(int i);
    int up, dn;
    up = (m_step == 0 || m_level[i] + m_step > m_duty[i]) ? m_duty[i] : m_level[i] + m_step;
    dn = (m_step == 0 || m_level[i] <= m_step) ? 0 : m_level[i] - m_step;
    if (blink_in[i]) begin
      if (m_state[i] == S_ON) begin
        m_level[i] = m_duty[i];
      end else begin
        m_level[i] = up;
        m_state[i] = (up == m_duty[i]) ? S_ON : S_RISE;
      end
    end else if (m_state[i] != S_OFF) begin
      m_level[i] = dn;
      m_state[i] = (dn == 0) ? S_OFF : S_FALL;
    end
  endfunction

  function automatic void model_clock(bit rst, bit we, int a, logic [31:0] d);
    bit tick, bnd;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_duty[i] = 0; m_level[i] = 0; m_state[i] = S_OFF;
      end
      m_pre = 0; m_step = 0; m_pc = 0; m_cnt = 0; m_led = '0;
      return;
    end
    tick = (m_pc == m_pre);
    bnd  = tick && (m_cnt == 255);
    for (int i = 0; i < 4; i++) m_led[i] = (m_cnt < m_level[i]);
    if (bnd) for (int i = 0; i < 4; i++) model_fade(i);
    if (tick) m_cnt = (m_cnt + 1) % 256;
    m_pc = tick ? 0 : m_pc + 1;
    if (we) begin
      if (a < 4) m_duty[a] = int'(d[7:0]);
      else if (a == 4) begin
        m_pre = int'(d[15:0]);
        m_pc  = 0;
      end else if (a == 5) m_step = int'(d[7:0]);
    end
  endfunction

  function automatic logic [31:0] model_rd(int a);
    if (a < 4) return 32'(m_duty[a]);
    if (a == 4) return 32'(m_pre);
    if (a == 5) return 32'(m_step);
    if (a == 6) return 32'((m_level[3] << 24) | (m_level[2] << 16) | (m_level[1] << 8) | m_level[0]);
    return 32'd0;
  endfunction

  task automatic drive(bit rst, bit c, bit w, int a, logic [31:0] d);
    exp_t e;
    reset   = rst;
    cs      = c;
    write   = w;
    read    = c && !w;
    addr    = 5'(a);
    wr_data = d;
    model_clock(rst, c && w, a, d);
    e.led = m_led;
    e.rd  = model_rd(a);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n, int a);
    repeat (n) drive(1'b0, 1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic wr(int a, logic [31:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d);
  endtask

  // Monitor: the DUT presents led and rd_data every clock.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      if (led !== mon_e.led || rd_data !== mon_e.rd) begin
        bad++;
        $display("FAIL cycle_check t=%0t addr=%0d led=%h rd=%h want led=%h rd=%h",
                 $time, addr, led, rd_data, mon_e.led, mon_e.rd);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t queue=%0d", $time, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    blink_in = '0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 32'd0);
    for (int a = 0; a < 32; a++) idle(1, a);

    // Instant fade, duty 64 on channel 0.
    wr(0, 32'd64);
    blink_in[0] = 1'b1;
    idle(700, 6);

    // Stepped fade down, up, down with step 16.
    wr(5, 32'd16);
    blink_in[0] = 1'b0;
    idle(1400, 6);
    blink_in[0] = 1'b1;
    idle(1400, 6);
    blink_in[0] = 1'b0;
    idle(1400, 6);

    // Reverse mid-rise at level 32.
    blink_in[0] = 1'b1;
    idle(600, 6);
    blink_in[0] = 1'b0;
    idle(900, 6);

    // Register readback and ignored address.
    wr(2, 32'hAB);
    wr(4, 32'h1234);
    wr(9, 32'hFFFF_FFFF);
    idle(1, 2);
    idle(1, 4);
    idle(1, 9);

    // Slow prescaler with full duty.
    wr(4, 32'd3);
    wr(5, 32'd0);
    wr(0, 32'd255);
    blink_in = 4'b0001;
    idle(3300, 0);

    // Reset in the middle of a rise, then rise again.
    wr(4, 32'd0);
    wr(5, 32'd8);
    wr(1, 32'd200);
    blink_in = 4'b0011;
    idle(800, 6);
    drive(1'b1, 1'b0, 1'b0, 6, 32'd0);
    idle(300, 6);
    wr(5, 32'd8);
    wr(1, 32'd200);
    idle(1000, 6);

    for (int it = 0; it < 25; it++) begin
      blink_in = 4'($urandom);
      repeat ($urandom_range(0, 4)) begin
        int a;
        logic [31:0] d;
        a = $urandom_range(0, 9);
        d = $urandom;
        if (a == 4) d = 32'($urandom_range(0, 2));
        drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, d);
      end
      if ($urandom_range(0, 9) == 0) drive(1'b1, 1'b0, 1'b0, 6, 32'd0);
      idle($urandom_range(30, 900), $urandom_range(0, 8));
    end

    repeat (2) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain queue=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_dimmer.md
LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

Interface
REQ-001 The block SHALL have parameter W, default 4: number of LED channels.
REQ-002 The block SHALL have parameter RES, default 8: PWM counter and brightness width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cs  input  1  slot select
- read  input  1  bus read strobe
- write  input  1  bus write strobe
- addr  input  5  register address
- wr_data  input  32  write data
- rd_data  output  32  read data
- blink_in  input  W  on/off request per channel, from the blinking-LED core, same clock domain
- led  output  W  dimmed LED drive to the pins

Function
REQ-005 A write SHALL occur when cs && write; addresses 0..W-1 load duty_reg[addr] from wr_data[RES-1:0].
REQ-006 Address 4 SHALL load prescale from wr_data[15:0]; address 5 SHALL load fade_step from wr_data[RES-1:0]; writes to other addresses SHALL be ignored.
REQ-007 rd_data SHALL be combinational from addr:
- 0..3: zero-extended duty_reg
- 4: prescale
- 5: fade_step
- 6: {level[3],level[2],level[1],level[0]}
- else: 0
REQ-008 A prescaler SHALL assert tick for one clock every prescale+1 clocks; prescale=0 SHALL give tick every clock.
REQ-009 The PWM counter cnt (RES bits) SHALL increment on tick and wrap from 2^RES-1 to 0.
REQ-010 A period boundary SHALL be tick && cnt==2^RES-1.
REQ-011 The per-channel level and FSM state SHALL update only at a period boundary, sampling blink_in and duty_reg in that cycle; the new level SHALL apply from cnt=0.
REQ-012 led[i] SHALL be registered as (cnt < level[i]), one clock after cnt changes. level=0 SHALL keep the LED off; level=255 SHALL give 255/256 on.
REQ-013 Each channel FSM SHALL have four states: OFF, RISE, ON, FALL.
REQ-014 OFF: level=0; blink_in=1 -> RISE.
REQ-015 RISE: level=min(level+fade_step, duty); on reaching duty -> ON; blink_in=0 -> FALL, taking precedence over reaching duty.
REQ-016 ON: level=duty_reg, so a duty change applies at the next boundary; blink_in=0 -> FALL.
REQ-017 FALL: level=max(level-fade_step, 0); on reaching 0 -> OFF; blink_in=1 -> RISE.
REQ-018 fade_step=0 SHALL mean instant transitions: RISE sets level=duty and goes to ON; FALL sets level=0 and goes to OFF, both at the same boundary.
REQ-019 Add/subtract SHALL use RES+1 bits and then saturate; no wrap-around SHALL occur.
REQ-020 If duty drops below level during RISE, level SHALL clamp to duty and the state SHALL go to ON.
REQ-021 A write coinciding with a boundary SHALL take effect at the following boundary; the boundary uses the old value.
REQ-022 A prescale write SHALL restart the prescaler count at 0; cnt SHALL be unaffected.

Reset
REQ-023 Reset SHALL clear to 0: duty_reg, prescale, fade_step, prescaler count, cnt, every level, and led; every FSM SHALL go to OFF.
REQ-024 rd_data SHALL read 0 at all addresses after reset.
REQ-025 Reset mid-fade SHALL override every pending update in the same cycle.

Structure
REQ-026 Package led_dimmer_pkg SHALL hold the fade_state_t enum (OFF, RISE, ON, FALL) and the address constants ADDR_DUTY0, ADDR_PRESCALE=4, ADDR_STEP=5, ADDR_LEVEL=6.
REQ-027 Sub-module led_fade_channel SHALL hold one FSM plus its level register, generate-replicated W times.
REQ-028 The prescaler, cnt, and register file SHALL live in the top module.

Verification
REQ-029 prescale=0, step=0, duty0=64, blink_in[0]=1 -> after the first boundary, led[0] high exactly 64 of every 256 clocks.
REQ-030 step=16, duty0=64, blink_in[0] rises -> level0 reads 16, 32, 48, 64 on successive periods, then ON; blink_in[0] falls -> 48, 32, 16, 0, then OFF.
REQ-031 step=16, duty=64, blink_in drops when level=32 -> next level 16 (FALL), with no overshoot.
REQ-032 prescale=3 -> tick every 4 clocks, PWM period 1024 clocks; duty=255 -> led low exactly 4 clocks per period.
REQ-033 Write 0xAB to addr 2 and 0x1234 to addr 4 -> readback 0xAB and 0x1234; a write to addr 9 changes nothing.
REQ-034 Reset asserted mid-RISE -> next clock: led=0, level readback 0, all states OFF; re-rise starts from 0.
